// File: rtl/spi_slave_port.sv
// SPI mode-0 slave endpoint: oversampled pins, RX FIFO and a one-deep TX holding register.
// Define SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB first (default is MSB first).
module spi_slave_port #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  // Pin synchronizers are left unreset so a reset never fabricates an ss edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       byte_done_q, byte_done_d;

  logic [7:0] rx_shifted, tx_advanced;
  logic       tx_bit;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_shifted  = {mosi_s, rx_sh_q[7:1]};
  assign tx_advanced = {1'b0, tx_sh_q[7:1]};
  assign tx_bit      = tx_sh_q[0];
`else
  assign rx_shifted  = {rx_sh_q[6:0], mosi_s};
  assign tx_advanced = {tx_sh_q[6:0], 1'b0};
  assign tx_bit      = tx_sh_q[7];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    byte_done_d = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (ss_fall) state_d = StLoad;
      end
      StLoad: begin
        tx_sh_d = hold_full_q ? hold_q : 8'h00;
        if (hold_full_q) hold_full_d = 1'b0;
        cnt_d   = 4'd0;
        state_d = StShift;
      end
      StShift: begin
        if (sclk_rise) begin
          rx_sh_d     = rx_shifted;
          cnt_d       = cnt_q + 4'd1;
          byte_done_d = (cnt_q == 4'd7);
        end else if (sclk_fall) begin
          if (cnt_q == 4'd8) state_d = StLoad;
          else               tx_sh_d = tx_advanced;
        end
      end
      default: state_d = StIdle;
    endcase

    // Deselect abandons any partial byte; a completed byte is already in byte_done_q.
    if (ss_rise) begin
      state_d     = StIdle;
      cnt_d       = 4'd0;
      byte_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      tx_sh_q     <= 8'h00;
      rx_sh_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign miso     = busy ? tx_bit : 1'b0;
  assign tx_ready = ~hold_full_q;

  // Receive FIFO, first-word fall-through.
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty, full, push, pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && rx_ready;
  assign push    = byte_done_q && (!full || pop);
  assign overrun = byte_done_q && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= rx_sh_q;
  end

  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: tb/tb_spi_slave_port.sv
// Scoreboard bench for spi_slave_port: a master model drives frames, a monitor checks FIFO pops.
`timescale 1ns/1ps
module tb_spi_slave_port;

  localparam int Half = 8;

  logic       clk = 1'b0;
  logic       rst, sclk, ss, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, overrun, busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ov_count = 0;
  int         ov_base;
  logic [7:0] exp_q[$];
  logic [7:0] got, got2;

  spi_slave_port #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, inputs change just after the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ov_count++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected: got %h, required no byte", rx_data);
        end else begin
          check("rx_pop", rx_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ss_low();
    ss = 1'b0;
    cyc(10);
  endtask

  task automatic ss_high();
    cyc(Half);
    ss = 1'b1;
    cyc(12);
  endtask

  task automatic offer(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
      mosi = mo[i];
`else
      mosi = mo[7-i];
`endif
      cyc(Half);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      mi = {miso, mi[7:1]};
`else
      mi = {mi[6:0], miso};
`endif
      sclk = 1'b1;
      cyc(Half);
      sclk = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(1);
    check("reset_miso", 8'(miso), 8'h00);
    check("reset_tx_ready", 8'(tx_ready), 8'h01);
    check("reset_rx_valid", 8'(rx_valid), 8'h00);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_overrun", 8'(overrun), 8'h00);
    check("reset_busy", 8'(busy), 8'h00);

    // Single byte, empty holding register.
    rx_ready = 1'b0;
    ov_base  = ov_count;
    exp_q.push_back(8'hA5);
    ss_low();
    check("t1_busy_active", 8'(busy), 8'h01);
    xfer(8'hA5, 8, got);
    ss_high();
    check("t1_miso", got, 8'h00);
    check("t1_rx_valid", 8'(rx_valid), 8'h01);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_overrun", 8'(ov_count - ov_base), 8'h00);
    rx_ready = 1'b1;
    cyc(3);
    check("t1_drained", 8'(rx_valid), 8'h00);

    // Preloaded response.
    offer(8'h55);
    check("t2_tx_ready_full", 8'(tx_ready), 8'h00);
    exp_q.push_back(8'h3C);
    ss_low();
    check("t2_tx_ready_load", 8'(tx_ready), 8'h01);
    xfer(8'h3C, 8, got);
    ss_high();
    check("t2_miso", got, 8'h55);

    // Two bytes in one window, second response loaded mid-byte.
    offer(8'hAA);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    ss_low();
    fork
      xfer(8'h12, 8, got);
      begin
        cyc(40);
        offer(8'hBB);
      end
    join
    xfer(8'h34, 8, got2);
    ss_high();
    check("t3_miso_first", got, 8'hAA);
    check("t3_miso_second", got2, 8'hBB);

    // Overrun on the fifth byte with the consumer stalled.
    rx_ready = 1'b0;
    ov_base  = ov_count;
    for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
    ss_low();
    for (int b = 1; b <= 5; b++) xfer(8'(b), 8, got);
    ss_high();
    check("t4_overrun_count", 8'(ov_count - ov_base), 8'h01);
    check("t4_rx_valid", 8'(rx_valid), 8'h01);
    check("t4_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    cyc(8);
    check("t4_drained", 8'(rx_valid), 8'h00);

    // Aborted partial byte, then a full one.
    ss_low();
    xfer(8'hFF, 5, got);
    ss_high();
    check("t5_busy_between", 8'(busy), 8'h00);
    check("t5_no_push", 8'(rx_valid), 8'h00);
    exp_q.push_back(8'h81);
    ss_low();
    xfer(8'h81, 8, got);
    ss_high();
    check("t5_busy_after", 8'(busy), 8'h00);

    // 0x01 in whichever bit order the build uses.
    exp_q.push_back(8'h01);
    ss_low();
    xfer(8'h01, 8, got);
    ss_high();
    check("t6_miso", got, 8'h00);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc(1);
    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
